// File: rtl/float_add_dispatcher.sv
// float_add_dispatcher: operand FIFO and single-in-flight issue FSM in front of the
// multi-cycle FloatAdder, with a consumer-side result hold register and a WAIT watchdog.
module float_add_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [31:0]            InOp1,
  input  logic [31:0]            InOp2,
  input  logic                   InValid,
  output logic                   InReady,
  output logic [31:0]            AddOp1,
  output logic [31:0]            AddOp2,
  output logic                   AddValid,
  input  logic [31:0]            AddResult,
  input  logic                   AddResultValid,
  output logic [31:0]            OutResult,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Error
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [63:0]     mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [31:0]     add_op1_q, add_op1_d;
  logic [31:0]     add_op2_q, add_op2_d;
  logic            add_valid_q, add_valid_d;
  logic [31:0]     out_result_q, out_result_d;
  logic            out_valid_q, out_valid_d;
  logic            error_q, error_d;

  logic            full_s;
  logic            push_s;
  logic            pop_s;
  logic [63:0]     head_s;

  assign full_s = (count_q == CW'(DEPTH));
  assign push_s = InValid && !full_s;
  assign pop_s  = (state_q == S_ISSUE);
  assign head_s = mem_q[rd_ptr_q];

  // Occupancy update; a simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Issue/wait/hold sequencing, watchdog and result capture.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    out_result_d = out_result_q;
    out_valid_d  = out_valid_q;
    error_d      = error_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != {CW{1'b0}}) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        timer_d = {TW{1'b0}};
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the timeout edge still counts as delivered.
        if (AddResultValid) begin
          out_result_d = AddResult;
          out_valid_d  = 1'b1;
          state_d      = S_HOLD;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_HOLD: begin
        if (OutReady) begin
          out_valid_d = 1'b0;
          if (count_q != {CW{1'b0}}) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The FIFO head is latched on entry to ISSUE and held through WAIT.
  always_comb begin
    add_valid_d = (state_d == S_ISSUE);
    if (add_valid_d) begin
      add_op1_d = head_s[63:32];
      add_op2_d = head_s[31:0];
    end else begin
      add_op1_d = add_op1_q;
      add_op2_d = add_op2_q;
    end
  end

  // Operand storage; contents need no reset because the pointers guard them.
  always_ff @(posedge Clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {InOp1, InOp2};
    end
  end

  // Control and output registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= {PW{1'b0}};
      rd_ptr_q     <= {PW{1'b0}};
      count_q      <= {CW{1'b0}};
      timer_q      <= {TW{1'b0}};
      add_op1_q    <= 32'd0;
      add_op2_q    <= 32'd0;
      add_valid_q  <= 1'b0;
      out_result_q <= 32'd0;
      out_valid_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      add_op1_q    <= add_op1_d;
      add_op2_q    <= add_op2_d;
      add_valid_q  <= add_valid_d;
      out_result_q <= out_result_d;
      out_valid_q  <= out_valid_d;
      error_q      <= error_d;
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
    end
  end

  assign InReady   = !full_s;
  assign AddOp1    = add_op1_q;
  assign AddOp2    = add_op2_q;
  assign AddValid  = add_valid_q;
  assign OutResult = out_result_q;
  assign OutValid  = out_valid_q;
  assign Count     = count_q;
  assign Error     = error_q;

endmodule

// File: tb/tb_float_add_dispatcher.sv
// Randomized bench for float_add_dispatcher: a FloatAdder-like responder plus queues
// holding accepted pairs (issue order) and expected sums (delivery order).
module tb_float_add_dispatcher;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [31:0]   InOp1 = 32'd0;
  logic [31:0]   InOp2 = 32'd0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [31:0]   AddOp1, AddOp2;
  logic          AddValid;
  logic [31:0]   AddResult = 32'd0;
  logic          AddResultValid = 1'b0;
  logic [31:0]   OutResult;
  logic          OutValid;
  logic          OutReady = 1'b0;
  logic [CW-1:0] Count;
  logic          Error;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int av_count = 0;
  int rv_delay = 4;     // 0: adder never answers
  bit rv_random = 1'b0;
  int ready_mode = 1;   // 0 never, 1 always, 2 random
  logic [63:0] pair_q[$];
  logic [31:0] sum_q[$];

  float_add_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset),
    .InOp1(InOp1), .InOp2(InOp2), .InValid(InValid), .InReady(InReady),
    .AddOp1(AddOp1), .AddOp2(AddOp2), .AddValid(AddValid),
    .AddResult(AddResult), .AddResultValid(AddResultValid),
    .OutResult(OutResult), .OutValid(OutValid), .OutReady(OutReady),
    .Count(Count), .Error(Error)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    real m;
    int e;
    if (f[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    real a;
    int e;
    logic s;
    logic [22:0] man;
    if (r == 0.0) return 32'd0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    man = 23'($rtoi((a - 1.0) * 8388608.0));
    return {s, 8'(e + 127), man};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] rand_float();
    return {1'($urandom), 8'($urandom_range(134, 120)), 23'($urandom)};
  endfunction

  // FloatAdder stand-in: checks issue order, answers after the chosen delay.
  int rv_cnt = 0;
  logic [31:0] rv_res = 32'd0;
  logic av_prev = 1'b0;
  always @(negedge Clock) begin : adder_model
    int d;
    logic [63:0] pr;
    AddResultValid = 1'b0;
    AddResult = $urandom;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        AddResultValid = 1'b1;
        AddResult = rv_res;
      end
    end
    if (AddValid) begin
      av_count++;
      check_eq("addvalid_pulse", 32'(av_prev), 32'd0);
      check_eq("issue_nonempty", 32'(pair_q.size() != 0), 32'd1);
      if (pair_q.size() != 0) begin
        pr = pair_q.pop_front();
        check_eq("issue_op1", AddOp1, pr[63:32]);
        check_eq("issue_op2", AddOp2, pr[31:0]);
        d = rv_random ? int'($urandom_range(6, 1)) : rv_delay;
        rv_cnt = d;
        rv_res = fadd(pr[63:32], pr[31:0]);
        // Answers later than the watchdog are dropped by the dispatcher.
        if (d != 0 && d <= TIMEOUT) sum_q.push_back(rv_res);
      end
    end
    av_prev = AddValid;
  end

  // Consumer: drives OutReady, checks delivery order and hold stability.
  logic ov_prev = 1'b0;
  logic took_prev = 1'b0;
  logic [31:0] or_prev = 32'd0;
  always @(negedge Clock) begin : consumer
    logic [31:0] e;
    case (ready_mode)
      0:       OutReady = 1'b0;
      1:       OutReady = 1'b1;
      default: OutReady = 1'($urandom);
    endcase
    if (OutValid && ov_prev && !took_prev) check_eq("hold_stable", OutResult, or_prev);
    if (OutValid && OutReady) begin
      check_eq("out_expected", 32'(sum_q.size() != 0), 32'd1);
      if (sum_q.size() != 0) begin
        e = sum_q.pop_front();
        check_eq("out_result", OutResult, e);
      end
    end
    took_prev = OutValid && OutReady;
    ov_prev = OutValid;
    or_prev = OutResult;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    InValid = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    pair_q.delete();
    sum_q.delete();
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
    int g;
    g = 0;
    InOp1 = a;
    InOp2 = b;
    InValid = 1'b1;
    while (!InReady && g < 200) begin tick(); g++; end
    check_eq("push_wait", 32'(g < 200), 32'd1);
    pair_q.push_back({a, b});
    tick();
    InValid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while ((pair_q.size() != 0 || sum_q.size() != 0 || Count != '0 || OutValid || AddValid)
           && g < 500) begin
      tick();
      g++;
    end
    check_eq(tag, 32'(g < 500), 32'd1);
    repeat (3) tick();
  endtask

  initial begin : main
    int g;
    int t0;
    int av0;
    repeat (2) tick();
    Reset = 1'b0;
    check_eq("rst_inready", 32'(InReady), 32'd1);
    check_eq("rst_count", 32'(Count), 32'd0);
    check_eq("rst_addvalid", 32'(AddValid), 32'd0);
    check_eq("rst_outvalid", 32'(OutValid), 32'd0);
    check_eq("rst_error", 32'(Error), 32'd0);
    check_eq("rst_outresult", OutResult, 32'd0);
    check_eq("rst_addop1", AddOp1, 32'd0);

    // 1: single op, latency and one-cycle OutValid
    ready_mode = 1;
    rv_delay = 4;
    av0 = av_count;
    push_pair(32'h3F800000, 32'h3F800000);
    t0 = cyc;
    g = 0;
    while (!OutValid && g < 50) begin tick(); g++; end
    check_eq("t1_latency", 32'(cyc - t0), 32'd6);
    check_eq("t1_result", OutResult, 32'h40000000);
    tick();
    check_eq("t1_outvalid_drop", 32'(OutValid), 32'd0);
    check_eq("t1_pulses", 32'(av_count - av0), 32'd1);
    check_eq("t1_error", 32'(Error), 32'd0);

    // 2: back-pressured result is held; queued op waits
    ready_mode = 0;
    push_pair(32'h3FC00000, 32'hBF000000);
    g = 0;
    while (!OutValid && g < 50) begin tick(); g++; end
    check_eq("t2_result", OutResult, 32'h3F800000);
    av0 = av_count;
    push_pair(32'h40000000, 32'h40000000);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("t2_hold_valid", 32'(OutValid), 32'd1);
      check_eq("t2_hold_result", OutResult, 32'h3F800000);
    end
    check_eq("t2_no_issue", 32'(av_count - av0), 32'd0);
    ready_mode = 1;
    drain("t2_drain");
    check_eq("t2_second_issue", 32'(av_count - av0), 32'd1);

    // 3: fill to full, sixth push held off until a pop
    ready_mode = 0;
    for (int i = 0; i < 5; i++) push_pair(rand_float(), rand_float());
    check_eq("t3_count_full", 32'(Count), 32'(DEPTH));
    check_eq("t3_inready_low", 32'(InReady), 32'd0);
    fork
      push_pair(rand_float(), rand_float());
      begin
        for (int i = 0; i < 8; i++) begin
          tick();
          check_eq("t3_held_off", 32'(InReady), 32'd0);
        end
        ready_mode = 1;
        g = 0;
        while (!InReady && g < 50) begin tick(); g++; end
        check_eq("t3_reassert", 32'(g < 50), 32'd1);
        check_eq("t3_count_after_pop", 32'(Count), 32'(DEPTH - 1));
      end
    join
    drain("t3_drain");

    // 4a: answer on the timeout edge is delivered, no error
    rv_delay = TIMEOUT;
    push_pair(rand_float(), rand_float());
    drain("t4a_drain");
    check_eq("t4a_error", 32'(Error), 32'd0);

    // 4: answer one cycle too late -> timeout, next pair issued
    rv_delay = TIMEOUT + 1;
    push_pair(rand_float(), rand_float());
    push_pair(rand_float(), rand_float());
    g = 0;
    while (!AddValid && g < 20) begin tick(); g++; end
    t0 = cyc;
    @(negedge Clock);
    #1;
    rv_delay = 4;
    g = 0;
    while (!Error && g < 100) begin tick(); g++; end
    check_eq("t4_timeout_cycles", 32'(cyc - t0), 32'(TIMEOUT + 1));
    drain("t4_drain");
    check_eq("t4_error_sticky", 32'(Error), 32'd1);

    // 5: reset during WAIT; late answer ignored
    do_reset();
    check_eq("t5_error_clear", 32'(Error), 32'd0);
    rv_delay = 4;
    push_pair(rand_float(), rand_float());
    g = 0;
    while (!AddValid && g < 20) begin tick(); g++; end
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    pair_q.delete();
    sum_q.delete();
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("t5_outvalid", 32'(OutValid), 32'd0);
      check_eq("t5_count", 32'(Count), 32'd0);
      check_eq("t5_inready", 32'(InReady), 32'd1);
      check_eq("t5_error", 32'(Error), 32'd0);
    end

    // 6: push on the pop edge at DEPTH-1
    ready_mode = 0;
    for (int i = 0; i < 4; i++) push_pair(rand_float(), rand_float());
    check_eq("t6_count_pre", 32'(Count), 32'(DEPTH - 1));
    ready_mode = 1;
    g = 0;
    while (!AddValid && g < 50) begin tick(); g++; end
    check_eq("t6_issue_count", 32'(Count), 32'(DEPTH - 1));
    push_pair(rand_float(), rand_float());
    check_eq("t6_count_same", 32'(Count), 32'(DEPTH - 1));
    drain("t6_drain");

    // stress: random pairs, gaps, OutReady and adder latency
    ready_mode = 2;
    rv_random = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(3, 0) == 0) tick();
      push_pair(rand_float(), rand_float());
    end
    drain("stress_drain");
    check_eq("stress_pairs_left", 32'(pair_q.size()), 32'd0);
    check_eq("stress_sums_left", 32'(sum_q.size()), 32'd0);
    check_eq("stress_error", 32'(Error), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d compares failed", n_err, n_vec);
    $fatal(1);
  end

endmodule
